// File: rtl/aes_mix_pkg.sv
// rtl/aes_mix_pkg.sv - GF(2^8) constants, helpers and FSM states for the column mixer
package aes_mix_pkg;

    // Low byte of the Rijndael reduction polynomial 0x11B
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Matrix row 0 coefficients; row r is this row rotated right by r
    localparam logic [0:3][7:0] FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [0:3][7:0] INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mix_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant coefficient this folds to XORs
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h00;
        pw  = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ pw;
            pw = xtime(pw);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// rtl/gf_mix_column.sv - combinational forward/inverse mix of one 32-bit column
module gf_mix_column
    import aes_mix_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inverse,
    output logic [31:0] col_out
);

    logic [0:3][7:0] a;
    logic [0:3][7:0] b;
    logic [0:3][7:0] coef;

    assign a       = col_in;
    assign coef    = inverse ? INV_COEF : FWD_COEF;
    assign col_out = b;

    // Output row r pairs coefficient k with input row (r+k) mod 4
    always_comb begin
        b = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                b[r] = b[r] ^ gf_mul_const(a[2'(r + k)], coef[k]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - multi-cycle MixColumns/InvMixColumns engine with valid/ready handshake
module mix_columns_engine
    import aes_mix_pkg::*;
#(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inverse,
    input  logic [32*NB-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_state,
    output logic            busy
);

    localparam int GROUPS = NB / COLS_PER_CYCLE;
    localparam int IDXW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW     = $clog2(NB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GROUPS - 1);

    generate
        if (NB < 4 || NB > 8) begin : g_bad_nb
            $error("mix_columns_engine: NB must be within 4..8");
        end
        if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must divide NB");
        end
    endgenerate

    mix_state_e           state;
    logic [0:NB-1][31:0]  work;
    logic [IDXW-1:0]      idx;
    logic                 mode;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [CW-1:0]        col_sel [COLS_PER_CYCLE];
    logic [31:0]          mix_in  [COLS_PER_CYCLE];
    logic [31:0]          mix_out [COLS_PER_CYCLE];

    // Select the group of columns addressed by the current index
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_sel[j] = CW'(int'(idx) * COLS_PER_CYCLE + j);
            mix_in[j]  = work[col_sel[j]];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
            gf_mix_column u_mix (
                .col_in  (mix_in[g]),
                .inverse (mode),
                .col_out (mix_out[g])
            );
        end
    endgenerate

    // Control FSM: accept, mix one group per cycle in place, hold result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            work        <= '0;
            idx         <= '0;
            mode        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        work       <= in_state;
                        mode       <= in_inverse;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                        work[col_sel[j]] <= mix_out[j];
                    end
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // Working register is only exposed once complete, so partial mixes never leak
    assign out_state = out_valid_q ? work : '0;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - self-checking bench for mix_columns_engine in three configurations
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_inverse;
    logic         out_ready;
    logic [255:0] in_state;
    logic [1:0]   sel;

    logic [2:0]   in_valid_v;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   busy_v;
    logic [127:0] os0;
    logic [127:0] os1;
    logic [191:0] os2;
    logic [255:0] ost [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign in_valid_v[0] = in_valid && (sel == 2'd0);
    assign in_valid_v[1] = in_valid && (sel == 2'd1);
    assign in_valid_v[2] = in_valid && (sel == 2'd2);

    always_comb begin
        ost[0] = {128'b0, os0};
        ost[1] = {128'b0, os1};
        ost[2] = {64'b0, os2};
    end

    mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_inverse(in_inverse), .in_state(in_state[127:0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_state(os0), .busy(busy_v[0])
    );

    mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_inverse(in_inverse), .in_state(in_state[127:0]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_state(os1), .busy(busy_v[1])
    );

    mix_columns_engine #(.NB(6), .COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_inverse(in_inverse), .in_state(in_state[191:0]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_state(os2), .busy(busy_v[2])
    );

    // Reference: full polynomial product, then reduce modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Reference: matrix-times-column for every column of an nb-column state
    function automatic logic [255:0] mix_ref(input logic [255:0] st, input int nb, input bit inv);
        logic [7:0]   base [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [31:0]  col;
        logic [255:0] res;
        res = '0;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < nb; c++) begin
            col = st[32*(nb-1-c) +: 32];
            for (int k = 0; k < 4; k++) a[k] = col[24-8*k +: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(base[(k - r + 4) % 4], a[k]);
                res[32*(nb-1-c) + 24 - 8*r +: 8] = b;
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        for (int i = 32*nb; i < 256; i++) r[i] = 1'b0;
        return r;
    endfunction

    // Drive one transaction into DUT d; returns at DONE (or after the handshake if out_ready is high)
    task automatic run_txn(input int d, input logic [255:0] st, input logic inv,
                           output logic [255:0] res, output int lat, output bit flags_ok);
        int n;
        res = '0;
        lat = -1;
        flags_ok = 1'b1;
        sel = 2'(d);
        n = 0;
        while (!in_ready_v[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_v[d]) return;
        in_state   = st;
        in_inverse = inv;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_inverse = ~inv;
        in_state   = rand_state(8);
        n = 0;
        while (!out_valid_v[d] && n < 50) begin
            if (in_ready_v[d] || !busy_v[d]) flags_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid_v[d]) return;
        if (in_ready_v[d] || !busy_v[d]) flags_ok = 1'b0;
        lat = n;
        res = ost[d];
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (in_ready_v !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b want 000", in_ready_v); end
        checks++;
        if (out_valid_v !== 3'b000 || busy_v !== 3'b000) begin
            errors++; $display("FAIL reset_valid_busy: got out_valid=%b busy=%b want 000/000", out_valid_v, busy_v);
        end
        checks++;
        if (ost[0] !== '0 || ost[1] !== '0 || ost[2] !== '0) begin
            errors++; $display("FAIL reset_out_state: got %h %h %h want 0", ost[0], ost[1], ost[2]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_v !== 3'b111) begin errors++; $display("FAIL idle_in_ready: got %b want 111", in_ready_v); end
    endtask

    task automatic test_known_vectors();
        logic [255:0] res;
        int lat;
        bit ok;
        run_txn(0, 256'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, res, lat, ok);
        checks++;
        if (res[127:0] !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            errors++; $display("FAIL fwd_vector: got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", res[127:0]);
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL fwd_latency: got %0d want 4", lat); end
        run_txn(0, 256'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, res, lat, ok);
        checks++;
        if (res[127:0] !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
            errors++; $display("FAIL inv_vector: got %h want db135345f20a225c01010101c6c6c6c6", res[127:0]);
        end
        checks++;
        if (lat !== 4 || !ok) begin errors++; $display("FAIL inv_latency_flags: got lat=%0d flags=%0d want 4/1", lat, ok); end
    endtask

    task automatic test_random_serial();
        logic [255:0] st, res, exp;
        int lat;
        bit ok;
        bit inv;
        for (int i = 0; i < 6; i++) begin
            st  = rand_state(4);
            inv = 1'($urandom_range(0, 1));
            exp = mix_ref(st, 4, inv);
            run_txn(0, st, inv, res, lat, ok);
            checks++;
            if (res !== exp || lat !== 4 || !ok) begin
                errors++; $display("FAIL random_nb4_cpc1[%0d]: got %h lat=%0d flags=%0d want %h lat=4 flags=1", i, res[127:0], lat, ok, exp[127:0]);
            end
        end
    endtask

    task automatic test_full_parallel();
        logic [255:0] st, res, exp;
        int lat;
        bit ok;
        bit inv;
        run_txn(1, {128'b0, {4{32'hd4d4d4d5}}}, 1'b0, res, lat, ok);
        checks++;
        if (res[127:0] !== {4{32'hd5d5d7d6}}) begin
            errors++; $display("FAIL cpc4_vector: got %h want d5d5d7d6 x4", res[127:0]);
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL cpc4_latency: got %0d want 1", lat); end
        for (int i = 0; i < 4; i++) begin
            st  = rand_state(4);
            inv = 1'($urandom_range(0, 1));
            exp = mix_ref(st, 4, inv);
            run_txn(1, st, inv, res, lat, ok);
            checks++;
            if (res !== exp || lat !== 1 || !ok) begin
                errors++; $display("FAIL random_cpc4[%0d]: got %h lat=%0d want %h lat=1", i, res[127:0], lat, exp[127:0]);
            end
        end
    endtask

    task automatic test_nb6_roundtrip();
        logic [255:0] st, mid, back;
        int lat_f, lat_i;
        bit ok_f, ok_i;
        for (int i = 0; i < 3; i++) begin
            st = rand_state(6);
            run_txn(2, st, 1'b0, mid, lat_f, ok_f);
            checks++;
            if (mid !== mix_ref(st, 6, 1'b0)) begin
                errors++; $display("FAIL nb6_forward[%0d]: got %h want %h", i, mid[191:0], mix_ref(st, 6, 1'b0) >> 0);
            end
            run_txn(2, mid, 1'b1, back, lat_i, ok_i);
            checks++;
            if (back !== st) begin errors++; $display("FAIL nb6_roundtrip[%0d]: got %h want %h", i, back[191:0], st[191:0]); end
            checks++;
            if (lat_f !== 3 || lat_i !== 3) begin
                errors++; $display("FAIL nb6_latency[%0d]: got %0d/%0d want 3/3", i, lat_f, lat_i);
            end
            checks++;
            if (!ok_f || !ok_i) begin errors++; $display("FAIL nb6_in_ready_busy[%0d]: got flags %0d/%0d want 1/1", i, ok_f, ok_i); end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] st, st2, res, exp;
        int lat, n;
        bit ok, stable;
        st  = rand_state(4);
        exp = mix_ref(st, 4, 1'b0);
        out_ready = 1'b0;
        run_txn(0, st, 1'b0, res, lat, ok);
        checks++;
        if (res !== exp || lat !== 4) begin
            errors++; $display("FAIL bp_result: got %h lat=%0d want %h lat=4", res[127:0], lat, exp[127:0]);
        end
        stable = 1'b1;
        sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_inverse = 1'($urandom_range(0, 1));
            in_state   = rand_state(8);
            @(posedge clk); #1;
            if (out_valid_v[0] !== 1'b1 || ost[0] !== exp || in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_hold: got unstable output or accept, want held %h", exp[127:0]); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
        st2 = rand_state(4);
        in_state   = st2;
        in_inverse = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
            errors++; $display("FAIL bp_resume_accept: got busy=%b in_ready=%b want 1/0", busy_v[0], in_ready_v[0]);
        end
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ost[0] !== mix_ref(st2, 4, 1'b1) || n !== 4) begin
            errors++; $display("FAIL bp_resume_result: got %h lat=%0d want %h lat=4", ost[0][127:0], n, mix_ref(st2, 4, 1'b1) >> 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        logic [255:0] res;
        int lat;
        bit ok;
        sel = 2'd0;
        in_state   = rand_state(4);
        in_inverse = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || ost[0] !== '0) begin
            errors++; $display("FAIL abort_reset: got out_valid=%b busy=%b out_state=%h want 0/0/0", out_valid_v[0], busy_v[0], ost[0][127:0]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        run_txn(0, {128'b0, {4{32'h2d26314c}}}, 1'b0, res, lat, ok);
        checks++;
        if (res[127:0] !== {4{32'h4d7ebdf8}} || lat !== 4) begin
            errors++; $display("FAIL post_abort_txn: got %h lat=%0d want 4d7ebdf8 x4 lat=4", res[127:0], lat);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        in_state   = '0;
        sel        = 2'd0;
        test_reset();
        test_known_vectors();
        test_random_serial();
        test_full_parallel();
        test_nb6_roundtrip();
        test_backpressure();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
